// File: rtl/memory_initiator_pkg.sv
// Shared definitions for the memory initiator: state encoding, default sizing
// and the load-result helper used when building a response.
package memory_initiator_pkg;

    localparam int unsigned DEFAULT_ADDR_W         = 8;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;
    localparam int unsigned DATA_W                 = 8;
    localparam int unsigned CNT_W                  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2,
        RESPOND = 2'd3
    } state_t;

    // Load data returned to the CPU: zero for stores and for failed accesses.
    function automatic logic [DATA_W-1:0] load_data(
        input logic              is_write,
        input logic              is_error,
        input logic [DATA_W-1:0] data
    );
        return (is_write || is_error) ? '0 : data;
    endfunction

endpackage

// File: rtl/memory_initiator.sv
// CPU-side initiator driving a four-phase level handshake to a memory
// responder, with a per-phase timeout. All outputs are registered.
module memory_initiator
    import memory_initiator_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_value,
    input  logic [DATA_W-1:0] mem_read_value,
    input  logic              mem_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_error_q, resp_error_d;
    logic                req_ready_q, req_ready_d;
    logic                strobe;

    assign strobe = mem_read_q | mem_write_q;

    // State and output registers; reset drops strobes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            req_ready_q  <= req_ready_d;
        end
    end

    // Next-state and next-output logic for the handshake sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    state_d = ACCESS;
                    // A still-high acknowledge from the last access holds the strobe off.
                    mem_read_d  = !req_write && !mem_ready;
                    mem_write_d = req_write && !mem_ready;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (strobe && mem_ready) begin
                    rdata_d     = write_q ? '0 : mem_read_value;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    err_d       = 1'b1;
                    cnt_d       = '0;
                    state_d     = RELEASE;
                end else if (!strobe && !mem_ready) begin
                    mem_read_d  = !write_q;
                    mem_write_d = write_q;
                end
            end
            RELEASE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!mem_ready) begin
                    resp_valid_d = 1'b1;
                    resp_error_d = err_q;
                    resp_rdata_d = load_data(write_q, err_q, rdata_q);
                    state_d      = RESPOND;
                end else if (cnt_q == CNT_LAST) begin
                    err_d        = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                    state_d      = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_error      = resp_error_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = addr_q;
    assign mem_write_value = wdata_q;

endmodule

// File: tb/tb_memory_initiator.sv
// Bench for memory_initiator: directed table, randomized transactions against
// a transaction-level timing model, plus reset and back-to-back sequences.
module tb_memory_initiator;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_wdata;
    logic       resp_valid, resp_error;
    logic [7:0] resp_rdata;
    logic       mem_read, mem_write, mem_ready;
    logic [7:0] mem_address, mem_write_value, mem_read_value;

    int n_vec = 0;
    int n_bad = 0;

    // responder configuration: ack delay, release hold, stale-ack cycles
    int         cfg_d = 0;
    int         cfg_h = 0;
    int         stale_cycles = 0;
    logic [7:0] cfg_rd = 8'h00;
    int         hi = 0;
    int         lo = 0;
    bit         acked = 0;

    memory_initiator #(.ADDR_W(8), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_value(mem_write_value), .mem_read_value(mem_read_value),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Responder: updates mem_ready mid-cycle from the strobe it sees.
    always @(negedge clk) begin
        if (!rst_n) begin
            hi = 0; lo = 0; acked = 0; mem_ready = 1'b0; mem_read_value = 8'h00;
        end else if (mem_read || mem_write) begin
            hi++; lo = 0;
            if (hi > cfg_d) begin
                mem_ready = 1'b1; acked = 1; mem_read_value = cfg_rd;
            end else begin
                mem_ready = 1'b0; mem_read_value = ~cfg_rd;
            end
        end else begin
            hi = 0; mem_read_value = ~cfg_rd;
            if (acked) begin
                if (lo < cfg_h) begin mem_ready = 1'b1; lo++; end
                else begin mem_ready = 1'b0; acked = 0; lo = 0; end
            end else if (stale_cycles > 0) begin
                mem_ready = 1'b1; stale_cycles--;
            end else begin
                mem_ready = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: strobe length, latency (request cycle = 1), error, data.
    function automatic void model(input logic wr, input logic [7:0] rd, input int s, input int d,
                                  input int h, output int len, output int lat,
                                  output logic err, output logic [7:0] rdata);
        bit ok;
        int rel;
        ok  = (d + 1) <= (T - s);
        len = ok ? d + 1 : T - s;
        rel = !ok ? 1 : (h < T ? h + 1 : T);
        err = !ok || (h >= T);
        rdata = (wr || err) ? 8'h00 : rd;
        lat = s + len + rel + 2;
    endfunction

    task automatic run_txn(input string tag, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                           input logic [7:0] rd, input int s, input int d, input int h, input bit noise,
                           input int e_len, input int e_lat, input logic e_err, input logic [7:0] e_rdata);
        int len = 0, lat = 0, bad_strobe = 0, bad_hold = 0, bad_busy = 0;
        bit done = 0;
        logic got_err = 1'b0;
        logic [7:0] got_rd = 8'h00;
        @(posedge clk); #2;
        cfg_d = d; cfg_h = h; cfg_rd = rd; stale_cycles = s;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        @(negedge clk);
        chk({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        for (int n = 1; n <= 200 && !done; n++) begin
            @(posedge clk); #2;
            if (noise) begin
                req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            if (mem_read && mem_write) bad_strobe++;
            if (mem_read || mem_write) begin
                len++;
                if (mem_write !== wr) bad_strobe++;
                if (mem_address !== a) bad_hold++;
                if (wr && (mem_write_value !== wd)) bad_hold++;
            end
            if (req_ready !== 1'b0) bad_busy++;
            if (resp_valid === 1'b1) begin
                done = 1; lat = n + 1; got_err = resp_error; got_rd = resp_rdata;
            end
        end
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".completed"}, 32'(done), 32'd1);
        chk({tag, ".strobe_len"}, 32'(len), 32'(e_len));
        chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
        chk({tag, ".resp_error"}, 32'(got_err), 32'(e_err));
        chk({tag, ".resp_rdata"}, 32'(got_rd), 32'(e_rdata));
        chk({tag, ".strobe_kind"}, 32'(bad_strobe), 32'd0);
        chk({tag, ".addr_data_stable"}, 32'(bad_hold), 32'd0);
        chk({tag, ".busy_ready"}, 32'(bad_busy), 32'd0);
        chk({tag, ".pulse_one_cycle"}, 32'(resp_valid), 32'd0);
        chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
        repeat (h + 3) @(posedge clk);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] a, wd, rd;
        int         s, d, h;
        int         len, lat;
        logic       err;
        logic [7:0] rdata;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   len, lat, s, d, h, n_resp, bad, idle_cnt, n_st;
        logic err;
        logic [7:0] rdata, a, wd, rd;
        logic wr;
        bit   sw;

        tbl[0] = '{1'b0, 8'h05, 8'h00, 8'hA5, 0, 0,  0,  1,  4, 1'b0, 8'hA5};
        tbl[1] = '{1'b1, 8'h7F, 8'h3C, 8'h99, 0, 3,  0,  4,  7, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 8'h33, 8'h00, 8'h11, 0, 99, 0,  16, 19, 1'b1, 8'h00};
        tbl[3] = '{1'b0, 8'h44, 8'h00, 8'h5A, 0, 0,  99, 1,  19, 1'b1, 8'h00};
        tbl[4] = '{1'b1, 8'h21, 8'h77, 8'h00, 0, 15, 0,  16, 19, 1'b0, 8'h00};
        tbl[5] = '{1'b0, 8'h60, 8'h00, 8'hC3, 4, 0,  0,  1,  8, 1'b0, 8'hC3};
        tbl[6] = '{1'b0, 8'h0A, 8'h00, 8'h96, 0, 2,  15, 3,  21, 1'b0, 8'h96};
        tbl[7] = '{1'b1, 8'h55, 8'hE1, 8'h00, 4, 99, 0,  12, 19, 1'b1, 8'h00};

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.req_ready", 32'(req_ready), 32'd1);
        chk("reset.strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("reset.resp", 32'({resp_valid, resp_error, resp_rdata}), 32'd0);
        chk("reset.mem_address", 32'(mem_address), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_txn($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].s,
                    tbl[i].d, tbl[i].h, bit'(i % 2), tbl[i].len, tbl[i].lat, tbl[i].err, tbl[i].rdata);

        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom); a = 8'($urandom); wd = 8'($urandom); rd = 8'($urandom);
            s = ($urandom % 4 == 0) ? int'($urandom_range(1, 5)) : 0;
            d = int'($urandom_range(0, 20));
            h = ($urandom % 5 == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 3));
            model(wr, rd, s, d, h, len, lat, err, rdata);
            run_txn($sformatf("rnd%0d", i), wr, a, wd, rd, s, d, h, 1'($urandom), len, lat, err, rdata);
        end

        // reset in the middle of a load that is never acknowledged
        @(posedge clk); #2;
        cfg_d = 99; cfg_h = 0; stale_cycles = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h12;
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(posedge clk); #2;
        chk("rst.strobe_before", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst.strobes_async", 32'({mem_read, mem_write}), 32'd0);
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        n_resp = 0; n_st = 0;
        repeat (25) begin
            @(negedge clk);
            if (resp_valid) n_resp++;
            if (mem_read || mem_write) n_st++;
        end
        chk("rst.no_resp", 32'(n_resp), 32'd0);
        chk("rst.no_strobe", 32'(n_st), 32'd0);
        run_txn("post_rst", 1'b0, 8'h12, 8'h00, 8'h3E, 0, 1, 1, 1'b0, 2, 6, 1'b0, 8'h3E);

        // back-to-back: req_valid held, second request only taken from IDLE
        @(posedge clk); #2;
        cfg_d = 0; cfg_h = 0; cfg_rd = 8'h6B; stale_cycles = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'h44;
        n_resp = 0; bad = 0; idle_cnt = 0; sw = 0;
        for (int n = 0; n < 60 && n_resp < 2; n++) begin
            @(posedge clk); #2;
            if (n_resp == 1 && !sw) begin
                sw = 1; req_write = 1'b0; req_addr = 8'h20;
            end
            @(negedge clk);
            if (mem_read && mem_write) bad++;
            if (mem_write && (mem_address !== 8'h10 || n_resp != 0)) bad++;
            if (mem_read && (mem_address !== 8'h20 || n_resp != 1)) bad++;
            if (n_resp == 1 && req_ready === 1'b1) idle_cnt++;
            if (resp_valid === 1'b1) begin
                n_resp++;
                if (n_resp == 1) chk("b2b.first_rdata", 32'({resp_error, resp_rdata}), 32'd0);
                else chk("b2b.second_rdata", 32'({resp_error, resp_rdata}), 32'h6B);
            end
        end
        @(posedge clk); #2;
        req_valid = 1'b0;
        chk("b2b.responses", 32'(n_resp), 32'd2);
        chk("b2b.overlap", 32'(bad), 32'd0);
        chk("b2b.idle_between", 32'(idle_cnt), 32'd1);
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_initiator.md
MEMORY_INITIATOR -- requirements
Module: memory_initiator

Interface
REQ-001 Parameter ADDR_W, 8, address width of the request and memory ports.
REQ-002 Parameter TIMEOUT_CYCLES, 16, max cycles to wait for each handshake phase; legal range 2..255.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  1  CPU access request.
REQ-006 req_ready  out  1  initiator can accept a request this cycle.
REQ-007 req_write  in  1  1 = store, 0 = load; sampled with the request.
REQ-008 req_addr  in  ADDR_W  access address.
REQ-009 req_wdata  in  8  store byte.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  8  load byte; valid with resp_valid on loads.
REQ-012 resp_error  out  1  timeout flag; valid with resp_valid.
REQ-013 mem_read  out  1  read strobe to responder.
REQ-014 mem_write  out  1  write strobe to responder.
REQ-015 mem_address  out  ADDR_W  registered address.
REQ-016 mem_write_value  out  8  registered store byte.
REQ-017 mem_read_value  in  8  responder data.
REQ-018 mem_ready  in  1  responder acknowledge, level.

Function
REQ-019 The block SHALL implement a four-phase level handshake: strobe high -> mem_ready high -> strobe low -> mem_ready low.
REQ-020 The FSM SHALL have states IDLE, ACCESS, RELEASE, RESPOND.
REQ-021 IDLE: req_ready=1; on req_valid SHALL latch write, addr, wdata into registers and go ACCESS next cycle.
REQ-022 ACCESS: exactly one of mem_read/mem_write SHALL be high, mem_address/mem_write_value held stable from registers.
REQ-023 ACCESS: on mem_ready=1, SHALL capture mem_read_value (loads only), drop strobe next cycle, go RELEASE.
REQ-024 RELEASE: strobes low; on mem_ready=0 SHALL go RESPOND.
REQ-025 RESPOND: resp_valid=1 for exactly one cycle, then IDLE; minimum request-to-resp_valid latency 4 cycles with immediate responder.
REQ-026 A wait counter SHALL clear on each ACCESS/RELEASE entry and increment per cycle in those states.
REQ-027 Counter reaching TIMEOUT_CYCLES in ACCESS SHALL drop strobes, set error, go RELEASE.
REQ-028 Counter reaching TIMEOUT_CYCLES in RELEASE SHALL set error and go RESPOND.
REQ-029 resp_rdata SHALL be 0 on stores and on errored loads.
REQ-030 req_ready SHALL be 0 in all states except IDLE; req_valid outside IDLE SHALL be ignored.
REQ-031 mem_read and mem_write SHALL never be high simultaneously; outputs glitch-free (registered).
REQ-032 mem_ready high on IDLE entry SHALL delay strobe assertion until mem_ready is seen low (stale acknowledge).

Reset
REQ-033 rst_n low SHALL immediately force IDLE, counter 0, error 0, all outputs 0 except req_ready=1.
REQ-034 Reset mid-ACCESS SHALL drop strobes asynchronously; no resp_valid for the aborted request.

Structure
REQ-035 FSM state enum and default ADDR_W/TIMEOUT constants SHALL live in the shared memory package alongside the accessor definitions.
REQ-036 Single module, no sub-module; timeout counter is inline.

Verification
REQ-037 Load addr 0x05, responder ready next cycle returning 0xA5 -> mem_read high 1 cycle, resp_valid with rdata 0xA5, error 0, 4 cycles after request.
REQ-038 Store addr 0x7F data 0x3C, responder ready after 3 cycles -> mem_write held 4 cycles, address/data stable, resp_valid error 0, rdata 0.
REQ-039 Responder never asserts mem_ready -> strobe drops after 16 cycles, resp_valid with error 1, rdata 0.
REQ-040 Responder holds mem_ready high after strobe drop -> RESPOND after 16 RELEASE cycles with error 1.
REQ-041 rst_n low during ACCESS -> strobes 0 same cycle, no resp_valid, req_ready 1; next request completes normally.
REQ-042 Back-to-back requests with req_valid held -> second accepted only in IDLE after resp_valid; strobes never overlap.
